pipelined_execution_unit: RTL and testbench
===========================================

// Module: pipelined_execution_unit
// PURPOSE
//  Registered, handshaked successor of the combinational execution stage of simple_processor.
//  Accepts one decoded op per valid/ready beat and computes ALU results in 1 cycle.
//  Runs LOAD/STORE as multi-cycle DMEM req/ack transactions with an ack timeout.
//  Presents the result to writeback through a valid/ready output register.
// PARAMETERS
//  DATA_W      DATA_WIDTH (32)  operand/result/DMEM data width
//  ADDR_W      ADDR_WIDTH       DMEM address width (ADDR_W <= DATA_W)
//  IMM_W       6                immediate width, sign-extended to DATA_W
//  RD_W        5                destination register index width
//  MEM_TIMEOUT 16               cycles dmem_req_o may stay high without ack (>=1)
// PORTS
//  clk_i         in   1       clock, all state on rising edge
//  rst_ni        in   1       synchronous active-low reset
//  in_valid_i    in   1       op on func_i/rs*/imm_i/rd_addr_i valid
//  in_ready_o    out  1       unit accepts op this cycle
//  func_i        in   func_t  operation
//  rs1_data_i    in   DATA_W  source 1 / address base
//  rs2_data_i    in   DATA_W  source 2 / store data
//  imm_i         in   IMM_W   immediate
//  rd_addr_i     in   RD_W    destination register index
//  dmem_req_o    out  1       DMEM request, held until ack or timeout
//  dmem_addr_o   out  ADDR_W  DMEM address, stable while req high
//  dmem_we_o     out  1       1 = STORE, stable while req high
//  dmem_wdata_o  out  DATA_W  store data, stable while req high
//  dmem_rdata_i  in   DATA_W  load data, sampled in ack cycle
//  dmem_ack_i    in   1       DMEM transaction complete
//  out_valid_o   out  1       result valid
//  out_ready_i   in   1       writeback consumes result
//  rd_data_o     out  DATA_W  result
//  rd_addr_o     out  RD_W    destination index, registered with result
//  rd_we_o       out  1       result must be written to the RF
//  err_o         out  1       result is an error (illegal func or DMEM timeout)
// BEHAVIOUR
//  - Reset (rst_ni=0 at an edge): state IDLE; dmem_req_o, dmem_we_o, out_valid_o, rd_we_o and
//    err_o are 0; addr, wdata, rd_data and rd_addr are 0; timeout counter is 0.
//    in_ready_o is forced to 0 while rst_ni=0.
//  - FSM IDLE/MEM/DONE.
//  - in_ready_o = (IDLE) | (DONE & out_ready_i). An accept is in_valid_i & in_ready_o.
//  - Accept of an ALU op or an illegal func -> DONE next cycle (latency 1).
//  - Accept of LOAD/STORE -> MEM. Next cycle dmem_req_o=1 with addr/we/wdata registered.
//  - MEM:
//    - dmem_ack_i=1 -> drop req, capture dmem_rdata_i for LOAD -> DONE.
//    - No ack for MEM_TIMEOUT req cycles -> drop req, err_o=1, rd_we_o=0 -> DONE.
//  - DONE: out_valid_o=1 and all result outputs are stable until out_ready_i.
//    - out_ready_i & accept -> back-to-back (next op's DONE/MEM next cycle).
//    - out_ready_i & no accept -> IDLE.
//  - An ack while in IDLE/DONE is ignored. Reset in MEM abandons the transaction; req drops at that edge.
//  - Arithmetic: imm = sign-extend(imm_i) to DATA_W; add/sub wrap mod 2^DATA_W; SUB = rs1 + ~rs2 + 1.
//  - Logic ops: AND/OR/XOR/NOT bitwise.
//  - Shifts SLL/SLR/SLLI/SLRI are logical; amount = low $clog2(DATA_W) bits of rs2 or imm.
//  - Effective address = (rs1_data_i + imm)[ADDR_W-1:0].
//  - LOAD: rd_we_o=1, rd_data_o=rdata. STORE: rd_we_o=0, rd_data_o=0, dmem_wdata_o=rs2_data_i.
//  - ALU ops: rd_we_o=1. Illegal func: rd_we_o=0, rd_data_o=0, err_o=1.
// STRUCTURE
//  - simple_processor_pkg holds func_t, DATA_WIDTH and ADDR_WIDTH (existing).
//    Add exec_state_t {IDLE,MEM,DONE} and EXEC_MEM_TIMEOUT=16.
//  - Sub-module exec_alu: purely combinational; func_t, rs1, rs2, imm -> result and illegal flag.
//  - Top level holds the FSM, the timeout counter and the output/DMEM registers.
// TESTING
//  1. Reset: hold rst_ni=0 3 cycles with in_valid_i=1 -> in_ready_o=0, all outputs 0.
//     Release -> in_ready_o=1.
//  2. ADD rs1=32'hFFFF_FFFF, rs2=1, rd=3 -> 1 cycle later out_valid=1, rd_data=0, rd_addr=3, rd_we=1.
//     Hold out_ready=0 5 cycles -> outputs stable.
//  3. ADDI rs1=10 imm=6'b111110 -> 8.
//     SLLI rs1=1 imm=6'd33 -> 2 (amount masked to 1).
//     SUB 5-7 -> 32'hFFFF_FFFE.
//  4. LOAD rs1=0x40 imm=4, ack after 3 cycles with rdata=0xDEAD_BEEF -> req high 3 cycles at addr 0x44,
//     then rd_data=0xDEAD_BEEF, rd_we=1.
//  5. STORE rs2=0x1234, ack in first req cycle -> we=1 and wdata=0x1234 for 1 cycle; result rd_we=0.
//     Next: LOAD never acked -> req drops after 16 cycles, err_o=1, rd_we=0.
//  6. out_ready_i=1 and in_valid_i=1 streaming 4 ALU ops -> one result per cycle.
//     Reset asserted mid-MEM -> req=0 after that edge; late ack ignored.

Source files
------------

// File: rtl/simple_processor_pkg.sv
// Shared types and constants for simple_processor and its pipelined execution unit.
package simple_processor_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int ADDR_WIDTH       = 16;
  localparam int EXEC_MEM_TIMEOUT = 16;

  // Encodings 13..15 are unassigned and decode as illegal.
  typedef enum logic [3:0] {
    FUNC_ADD   = 4'd0,
    FUNC_SUB   = 4'd1,
    FUNC_AND   = 4'd2,
    FUNC_OR    = 4'd3,
    FUNC_XOR   = 4'd4,
    FUNC_NOT   = 4'd5,
    FUNC_SLL   = 4'd6,
    FUNC_SLR   = 4'd7,
    FUNC_ADDI  = 4'd8,
    FUNC_SLLI  = 4'd9,
    FUNC_SLRI  = 4'd10,
    FUNC_LOAD  = 4'd11,
    FUNC_STORE = 4'd12
  } func_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_DONE = 2'd2
  } exec_state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: ALU results, effective address for LOAD/STORE, and illegal-func flag.
module exec_alu
  import simple_processor_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int IMM_W  = 6
) (
  input  func_t             func_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              illegal_o,
  output logic              mem_o,
  output logic              store_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] imm_ext;
  assign imm_ext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    mem_o     = 1'b0;
    store_o   = 1'b0;
    case (func_i)
      FUNC_ADD:   result_o = rs1_i + rs2_i;
      FUNC_SUB:   result_o = rs1_i + ~rs2_i + DATA_W'(1);
      FUNC_AND:   result_o = rs1_i & rs2_i;
      FUNC_OR:    result_o = rs1_i | rs2_i;
      FUNC_XOR:   result_o = rs1_i ^ rs2_i;
      FUNC_NOT:   result_o = ~rs1_i;
      FUNC_SLL:   result_o = rs1_i << rs2_i[SH_W-1:0];
      FUNC_SLR:   result_o = rs1_i >> rs2_i[SH_W-1:0];
      FUNC_ADDI:  result_o = rs1_i + imm_ext;
      FUNC_SLLI:  result_o = rs1_i << imm_ext[SH_W-1:0];
      FUNC_SLRI:  result_o = rs1_i >> imm_ext[SH_W-1:0];
      FUNC_LOAD: begin
        result_o = rs1_i + imm_ext;
        mem_o    = 1'b1;
      end
      FUNC_STORE: begin
        result_o = rs1_i + imm_ext;
        mem_o    = 1'b1;
        store_o  = 1'b1;
      end
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_execution_unit.sv
// Registered execution stage: 1-cycle ALU ops, DMEM req/ack LOAD/STORE with timeout,
// valid/ready result register toward writeback.
//   state | meaning
//   IDLE  | no op held, ready for input
//   MEM   | DMEM request outstanding, timeout counting down
//   DONE  | result held on outputs until out_ready_i
module pipelined_execution_unit
  import simple_processor_pkg::*;
#(
  parameter int DATA_W      = DATA_WIDTH,
  parameter int ADDR_W      = ADDR_WIDTH,
  parameter int IMM_W       = 6,
  parameter int RD_W        = 5,
  parameter int MEM_TIMEOUT = EXEC_MEM_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  func_t             func_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [RD_W-1:0]   rd_addr_i,
  output logic              dmem_req_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [RD_W-1:0]   rd_addr_o,
  output logic              rd_we_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  exec_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [RD_W-1:0]   rd_addr_q, rd_addr_d;
  logic              rd_we_q, rd_we_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_illegal, alu_mem, alu_store;
  logic              accept;

  exec_alu #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_alu (
    .func_i    (func_i),
    .rs1_i     (rs1_data_i),
    .rs2_i     (rs2_data_i),
    .imm_i     (imm_i),
    .result_o  (alu_result),
    .illegal_o (alu_illegal),
    .mem_o     (alu_mem),
    .store_o   (alu_store)
  );

  assign in_ready_o = rst_ni & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    rd_addr_d = rd_addr_q;
    rd_we_d   = rd_we_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready_i && !accept) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          rd_addr_d = rd_addr_i;
          if (alu_mem) begin
            state_d   = S_MEM;
            cnt_d     = CNT_W'(MEM_TIMEOUT - 1);
            req_d     = 1'b1;
            addr_d    = alu_result[ADDR_W-1:0];
            we_d      = alu_store;
            wdata_d   = rs2_data_i;
            rd_data_d = '0;
            rd_we_d   = 1'b0;
            err_d     = 1'b0;
          end else begin
            state_d   = S_DONE;
            rd_data_d = alu_illegal ? '0 : alu_result;
            rd_we_d   = ~alu_illegal;
            err_d     = alu_illegal;
          end
        end
      end
      S_MEM: begin
        if (dmem_ack_i) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) begin
            rd_data_d = dmem_rdata_i;
            rd_we_d   = 1'b1;
          end
        end else if (cnt_q == '0) begin
          // Last allowed request cycle passed without ack.
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
      rd_we_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
      rd_we_q   <= rd_we_d;
      err_q     <= err_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_we_o    = we_q;
  assign dmem_wdata_o = wdata_q;
  assign out_valid_o  = (state_q == S_DONE);
  assign rd_data_o    = rd_data_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_we_o      = rd_we_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_pipelined_execution_unit.sv
// Directed bench for pipelined_execution_unit: ALU vector table plus DMEM/reset sequences.
module tb_pipelined_execution_unit;
  import simple_processor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  func_t       func;
  logic [31:0] rs1, rs2;
  logic [5:0]  imm;
  logic [4:0]  rd_addr_in;
  logic        req;
  logic [15:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd_data;
  logic [4:0]  rd_addr_out;
  logic        rd_we;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_execution_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .func_i       (func),
    .rs1_data_i   (rs1),
    .rs2_data_i   (rs2),
    .imm_i        (imm),
    .rd_addr_i    (rd_addr_in),
    .dmem_req_o   (req),
    .dmem_addr_o  (addr),
    .dmem_we_o    (we),
    .dmem_wdata_o (wdata),
    .dmem_rdata_i (rdata),
    .dmem_ack_i   (ack),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .rd_data_o    (rd_data),
    .rd_addr_o    (rd_addr_out),
    .rd_we_o      (rd_we),
    .err_o        (err)
  );

  typedef struct {
    func_t       f;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  im;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input func_t f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] im, input logic [4:0] rd);
    in_valid   = 1'b1;
    func       = f;
    rs1        = a;
    rs2        = b;
    imm        = im;
    rd_addr_in = rd;
  endtask

  task automatic chk_result(input string name, input logic [31:0] d, input logic [4:0] rd,
                            input logic w, input logic e);
    chk1({name, ".valid"}, out_valid, 1'b1);
    chk32({name, ".data"}, rd_data, d);
    chk32({name, ".rd"}, 32'(rd_addr_out), 32'(rd));
    chk1({name, ".we"}, rd_we, w);
    chk1({name, ".err"}, err, e);
  endtask

  initial begin
    int n;
    logic [31:0] held;

    vecs[0]  = '{FUNC_ADD,  32'hFFFF_FFFF, 32'h1,         6'd0,       5'd3,  32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{FUNC_ADDI, 32'd10,        32'h0,         6'b111110,  5'd4,  32'd8,         1'b1, 1'b0};
    vecs[2]  = '{FUNC_SLLI, 32'd1,         32'h0,         6'd33,      5'd5,  32'd2,         1'b1, 1'b0};
    vecs[3]  = '{FUNC_SUB,  32'd5,         32'd7,         6'd0,       5'd6,  32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[4]  = '{FUNC_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 6'd0,       5'd7,  32'hF000_F000, 1'b1, 1'b0};
    vecs[5]  = '{FUNC_OR,   32'h0F0F_0000, 32'h0000_00F0, 6'd0,       5'd8,  32'h0F0F_00F0, 1'b1, 1'b0};
    vecs[6]  = '{FUNC_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 6'd0,       5'd9,  32'h5555_5555, 1'b1, 1'b0};
    vecs[7]  = '{FUNC_NOT,  32'h0000_FFFF, 32'h0,         6'd0,       5'd10, 32'hFFFF_0000, 1'b1, 1'b0};
    vecs[8]  = '{FUNC_SLL,  32'd1,         32'd36,        6'd0,       5'd11, 32'h0000_0010, 1'b1, 1'b0};
    vecs[9]  = '{FUNC_SLR,  32'h8000_0000, 32'd31,        6'd0,       5'd12, 32'h0000_0001, 1'b1, 1'b0};
    vecs[10] = '{FUNC_SLRI, 32'hF000_0000, 32'h0,         6'd4,       5'd13, 32'h0F00_0000, 1'b1, 1'b0};
    vecs[11] = '{func_t'(4'hF), 32'h1234,  32'h5678,      6'd1,       5'd14, 32'h0,         1'b0, 1'b1};
    vecs[12] = '{FUNC_ADDI, 32'd1,         32'h0,         6'b011111,  5'd31, 32'h0000_0020, 1'b1, 1'b0};

    // Reset held 3 cycles with a pending op
    rst_n = 1'b0; ack = 1'b0; rdata = '0; out_ready = 1'b0;
    drive(FUNC_ADD, 32'h1, 32'h1, 6'd0, 5'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst.in_ready", in_ready, 1'b0);
    chk1("rst.out_valid", out_valid, 1'b0);
    chk1("rst.req", req, 1'b0);
    chk1("rst.we", we, 1'b0);
    chk1("rst.rd_we", rd_we, 1'b0);
    chk1("rst.err", err, 1'b0);
    chk32("rst.addr", 32'(addr), 32'h0);
    chk32("rst.wdata", wdata, 32'h0);
    chk32("rst.rd_data", rd_data, 32'h0);
    chk32("rst.rd_addr", 32'(rd_addr_out), 32'h0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1 chk1("rel.in_ready", in_ready, 1'b1);

    // ADD wrap, result held while writeback stalls
    @(negedge clk);
    drive(FUNC_ADD, 32'hFFFF_FFFF, 32'h1, 6'd0, 5'd3);
    @(negedge clk);
    chk_result("add", 32'h0, 5'd3, 1'b1, 1'b0);
    drive(FUNC_SUB, 32'h9, 32'h1, 6'd0, 5'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_result("hold", 32'h0, 5'd3, 1'b1, 1'b0);
      chk1("hold.in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk1("drain.out_valid", out_valid, 1'b0);

    // Streaming ALU table, one result per cycle
    for (int i = 0; i < 13; i++) begin
      if (i > 0) chk_result($sformatf("vec%0d", i - 1), vecs[i-1].exp_data, vecs[i-1].rd,
                            vecs[i-1].exp_we, vecs[i-1].exp_err);
      chk1($sformatf("vec%0d.in_ready", i), in_ready, 1'b1);
      drive(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].rd);
      @(negedge clk);
    end
    chk_result("vec12", vecs[12].exp_data, vecs[12].rd, vecs[12].exp_we, vecs[12].exp_err);
    in_valid = 1'b0;
    @(negedge clk);

    // LOAD acked in the third request cycle
    drive(FUNC_LOAD, 32'h40, 32'h0, 6'd4, 5'd17);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("ld.req%0d", i), req, 1'b1);
      chk32($sformatf("ld.addr%0d", i), 32'(addr), 32'h44);
      chk1($sformatf("ld.we%0d", i), we, 1'b0);
      chk1($sformatf("ld.valid%0d", i), out_valid, 1'b0);
      if (i == 2) begin ack = 1'b1; rdata = 32'hDEAD_BEEF; end
      @(negedge clk);
    end
    ack = 1'b0; rdata = '0;
    chk1("ld.req_drop", req, 1'b0);
    chk_result("ld", 32'hDEAD_BEEF, 5'd17, 1'b1, 1'b0);

    // STORE acked in first request cycle, then back-to-back LOAD that times out
    drive(FUNC_STORE, 32'h100, 32'h1234, 6'd0, 5'd7);
    @(negedge clk);
    in_valid = 1'b0;
    chk1("st.req", req, 1'b1);
    chk1("st.we", we, 1'b1);
    chk32("st.wdata", wdata, 32'h1234);
    chk32("st.addr", 32'(addr), 32'h100);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk1("st.req_drop", req, 1'b0);
    chk1("st.we_drop", we, 1'b0);
    chk_result("st", 32'h0, 5'd7, 1'b0, 1'b0);
    drive(FUNC_LOAD, 32'h200, 32'h0, 6'd0, 5'd21);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (req) n++;
      else if (n > 0) break;
    end
    chk32("to.req_cycles", n, 32'd16);
    chk1("to.req", req, 1'b0);
    chk_result("to", 32'h0, 5'd21, 1'b0, 1'b1);

    // Ack arriving in DONE must not disturb the held result
    out_ready = 1'b0; ack = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_result("done_ack", 32'h0, 5'd21, 1'b0, 1'b1);
    chk1("done_ack.req", req, 1'b0);
    ack = 1'b0; rdata = '0; out_ready = 1'b1;
    @(negedge clk);
    chk1("done_ack.idle", out_valid, 1'b0);

    // Reset in MEM abandons the request; a late ack is ignored
    drive(FUNC_LOAD, 32'h10, 32'h0, 6'd0, 5'd2);
    @(negedge clk);
    in_valid = 1'b0;
    chk1("mr.req", req, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk1("mr.req_drop", req, 1'b0);
    chk1("mr.in_ready", in_ready, 1'b0);
    chk1("mr.valid", out_valid, 1'b0);
    rst_n = 1'b1; ack = 1'b1; rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    ack = 1'b0;
    chk1("late.req", req, 1'b0);
    chk1("late.valid", out_valid, 1'b0);
    chk32("late.rd_data", rd_data, 32'h0);
    chk1("late.in_ready", in_ready, 1'b1);
    held = rd_data;
    @(negedge clk);
    chk32("late.stable", rd_data, held);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
